// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit for the E stage of the 5-stage MIPS core.
// Accepts MULT/MULTU/DIV/DIVU on a one-cycle start pulse. The result is computed
// at issue and held in pending registers. It is committed to HI/LO after a fixed
// latency, and busy is held high for that whole window. MTHI/MTLO write HI/LO
// directly when the unit is idle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, op[1:0]    issue pulse and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b [31:0]       rs / rt operands
//   we_hi, we_lo      MTHI / MTLO write enables
//   wdata [31:0]      MTHI / MTLO write data
//   busy              operation in flight (registered)
//   hi, lo [31:0]     architectural HI / LO (registered)
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_p_hi;
    logic [XLEN-1:0]    r_p_lo;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [XLEN-1:0]    w_p_hi_nxt;
    logic [XLEN-1:0]    w_p_lo_nxt;
    logic [XLEN-1:0]    w_hi_nxt;
    logic [XLEN-1:0]    w_lo_nxt;

    // Arithmetic datapath, evaluated from the issue-cycle operands.
    logic [2*XLEN-1:0]  w_prod_s;
    logic [2*XLEN-1:0]  w_prod_u;
    logic               w_sdiv;
    logic               w_q_neg;
    logic               w_r_neg;
    logic [XLEN-1:0]    w_dvd;
    logic [XLEN-1:0]    w_dvs;
    logic [XLEN-1:0]    w_uq;
    logic [XLEN-1:0]    w_ur;
    logic [XLEN-1:0]    w_res_hi;
    logic [XLEN-1:0]    w_res_lo;

    assign w_prod_s = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    assign w_prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

    // Signed divide works on magnitudes and fixes signs afterwards. The overflow
    // case 0x80000000 / -1 falls out naturally: |a| = 0x80000000, quotient keeps
    // that bit pattern and the remainder is zero.
    assign w_sdiv  = (op == 2'b10);
    assign w_q_neg = w_sdiv & (a[XLEN-1] ^ b[XLEN-1]);
    assign w_r_neg = w_sdiv & a[XLEN-1];
    assign w_dvd   = (w_sdiv & a[XLEN-1]) ? (~a + XLEN'(1)) : a;
    // A zero divisor is replaced by 1 so the divider never sees 0; the result is overridden below.
    assign w_dvs   = (b == '0) ? XLEN'(1)
                   : ((w_sdiv & b[XLEN-1]) ? (~b + XLEN'(1)) : b);
    assign w_uq    = w_dvd / w_dvs;
    assign w_ur    = w_dvd % w_dvs;

    // Result select by opcode.
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        unique case (op)
            2'b00: begin
                w_res_hi = w_prod_s[2*XLEN-1:XLEN];
                w_res_lo = w_prod_s[XLEN-1:0];
            end
            2'b01: begin
                w_res_hi = w_prod_u[2*XLEN-1:XLEN];
                w_res_lo = w_prod_u[XLEN-1:0];
            end
            default: begin
                if (b == '0) begin
                    w_res_hi = a;
                    w_res_lo = '1;
                end else begin
                    w_res_hi = w_r_neg ? (~w_ur + XLEN'(1)) : w_ur;
                    w_res_lo = w_q_neg ? (~w_uq + XLEN'(1)) : w_uq;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_cnt   <= w_cnt_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath updates: issue capture, countdown, commit, MTHI/MTLO.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_p_hi_nxt = r_p_hi;
        w_p_lo_nxt = r_p_lo;
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_nxt  = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    w_p_hi_nxt = w_res_hi;
                    w_p_lo_nxt = w_res_lo;
                end else begin
                    if (we_hi) w_hi_nxt = wdata;
                    if (we_lo) w_lo_nxt = wdata;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_hi_nxt = r_p_hi;
                    w_lo_nxt = r_p_lo;
                end
            end
            default: ;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total;
    int n_bad;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit #(
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check busy for n cycles with hi/lo held, then check the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_hi"}, hi, old_hi);
            check({tag, "_hold_lo"}, lo, old_lo);
            tick();
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // Multiplies and divides, issued back-to-back.
        run_op("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",      OP_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14);
        run_op("divu_zero", OP_DIVU,  32'd100,      32'd0,        10, 32'd100,      32'hFFFFFFFF);
        run_op("div_zero",  OP_DIV,   32'hFFFFFFF0, 32'd0,        10, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000);

        // MTHI then MTLO in consecutive idle cycles.
        we_hi = 1'b1;
        wdata = 32'h12345678;
        tick();
        we_hi = 1'b0;
        we_lo = 1'b1;
        wdata = 32'hCAFEF00D;
        check("mthi", hi, 32'h12345678);
        tick();
        we_lo = 1'b0;
        check("mtlo", lo, 32'hCAFEF00D);
        check("mtlo_hi_keep", hi, 32'h12345678);

        // Both writes in one cycle.
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'h00000055;
        tick();
        we_hi = 1'b0;
        we_lo = 1'b0;
        check("mtboth_hi", hi, 32'h55);
        check("mtboth_lo", lo, 32'h55);

        // MULT 3x4 with a stray MTLO and a stray start during busy: both ignored.
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd4;
        tick();
        check("ign_busy1", 32'(busy), 32'd1);
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        we_lo = 1'b1;
        wdata = 32'h0000DEAD;
        tick();
        start = 1'b0;
        we_lo = 1'b0;
        check("ign_lo_hold", lo, 32'h55);
        for (int i = 0; i < 4; i++) begin
            check("ign_busy", 32'(busy), 32'd1);
            tick();
        end
        check("ign_done", 32'(busy), 32'd0);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd12);

        // start together with MTHI in idle: start wins, write dropped.
        we_hi = 1'b1;
        wdata = 32'h0000BEEF;
        run_op("start_wins", OP_MULTU, 32'd2, 32'd5, 5, 32'd0, 32'd10);

        // Load nonzero hi/lo, then reset in the middle of a DIV.
        run_op("pre_rst", OP_MULTU, 32'h00010000, 32'h00030005, 5, 32'h00000003, 32'h00050000);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd50;
        b     = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_busy4", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("rst_no_commit_hi", hi, 32'h0);
            check("rst_no_commit_lo", lo, 32'h0);
            check("rst_no_busy", 32'(busy), 32'd0);
            tick();
        end
        run_op("after_rst", OP_MULTU, 32'd6, 32'd7, 5, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
